demux32_stream_router: RTL and testbench

32-bit 1-to-2 stream demultiplexer with valid/ready handshaking: the inverse of the 32-bit 2:1 layer mux. It accepts one word per cycle plus a route bit and delivers the word to output port 0 or port 1. Each output has a private 2-entry buffer, so a stalled destination never corrupts data and never blocks the other destination's queued words. It sits between the ALU result bus and two consumers (register write-back and flag/status path).

---
 rtl/router_constants.sv | 17 +
 rtl/stream_fifo2.sv | 62 ++++++
 rtl/demux32_stream_router.sv | 59 +++++
 tb/tb_demux32_stream_router.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_constants.sv
// Shared constants for the 32-bit stream router: widths, buffer depth, route encodings.
package router_constants;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned DEPTH         = 2;

    localparam logic ROUTE_P0 = 1'b0;
    localparam logic ROUTE_P1 = 1'b1;

    typedef logic [1:0] count_t;

    // A buffer is full once it holds DEPTH words.
    function automatic logic is_full(input count_t count);
        return count == count_t'(DEPTH);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// In-order 2-entry FIFO with registered head word; no push-to-head bypass.
module stream_fifo2
    import router_constants::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    count_t           count_q;
    count_t           count_d;
    logic             do_pop;

    // A pop on an empty buffer is ignored; push is pre-qualified by the caller.
    assign do_pop = pop && (count_q != 2'd0);

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage, pointers and count, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/demux32_stream_router.sv
// 1-to-2 stream demultiplexer: routes each accepted word into one of two private buffers.
module demux32_stream_router
    import router_constants::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ctl,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [1:0]       out0_count,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [1:0]       out1_count
);

    logic push0;
    logic push1;

    // Ready depends only on the selected buffer's registered count, never on outN_ready.
    always_comb begin
        in_ready = !is_full((in_ctl == ROUTE_P1) ? out1_count : out0_count);
        push0    = in_valid && in_ready && (in_ctl == ROUTE_P0);
        push1    = in_valid && in_ready && (in_ctl == ROUTE_P1);
    end

    stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push0),
        .push_data  (in_data),
        .pop        (out0_ready),
        .count      (out0_count),
        .head_valid (out0_valid),
        .head_data  (out0_data)
    );

    stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push1),
        .push_data  (in_data),
        .pop        (out1_ready),
        .count      (out1_count),
        .head_valid (out1_valid),
        .head_data  (out1_data)
    );

endmodule

// File: tb/tb_demux32_stream_router.sv
// Scoreboard bench for demux32_stream_router: per-port expected-word queues plus direct checks.
module tb_demux32_stream_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_ctl;
    logic [31:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic [1:0]  out0_count;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
    logic [1:0]  out1_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    demux32_stream_router #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctl     (in_ctl),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_count (out0_count),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: at negedge, handshakes about to complete at the next posedge are recorded.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check_eq("out0_spurious", q0.size(), 1);
                else check_eq("out0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check_eq("out1_spurious", q1.size(), 1);
                else check_eq("out1_data", out1_data, q1.pop_front());
            end
            if (in_valid && in_ready) begin
                if (in_ctl) q1.push_back(in_data);
                else q0.push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ctl, input logic [31:0] data);
        in_valid = 1'b1;
        in_ctl   = ctl;
        in_data  = data;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_ctl     = 1'b0;
        in_data    = 32'hDEADBEEF;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset with a transfer presented: it must be discarded.
        step();
        step();
        check_eq("rst_count0", 32'(out0_count), 0);
        check_eq("rst_count1", 32'(out1_count), 0);
        check_eq("rst_valid0", 32'(out0_valid), 0);
        check_eq("rst_valid1", 32'(out1_valid), 0);
        check_eq("rst_data0", out0_data, 0);
        check_eq("rst_data1", out1_data, 0);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        step();
        check_eq("post_rst_valid0", 32'(out0_valid), 0);
        check_eq("post_rst_valid1", 32'(out1_valid), 0);

        // Routing and one-cycle latency.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(1'b0, 32'h00000001);
        check_eq("route_v0", 32'(out0_valid), 1);
        check_eq("route_d0", out0_data, 32'h00000001);
        check_eq("route_v1_idle", 32'(out1_valid), 0);
        send(1'b1, 32'h80000000);
        check_eq("route_v1", 32'(out1_valid), 1);
        check_eq("route_d1", out1_data, 32'h80000000);
        check_eq("route_v0_idle", 32'(out0_valid), 0);
        in_valid = 1'b0;
        step();
        check_eq("route_drained0", 32'(out0_valid), 0);
        check_eq("route_drained1", 32'(out1_valid), 0);

        // Back-pressure to full, then release.
        out0_ready = 1'b0;
        send(1'b0, 32'hA);
        send(1'b0, 32'hB);
        in_data = 32'hC;
        #1;
        check_eq("full_count0", 32'(out0_count), 2);
        check_eq("full_in_ready", 32'(in_ready), 0);
        step();
        check_eq("full_hold_count0", 32'(out0_count), 2);
        check_eq("full_head", out0_data, 32'hA);
        out0_ready = 1'b1;
        step();
        check_eq("bp_pop_count0", 32'(out0_count), 1);
        check_eq("bp_freed_ready", 32'(in_ready), 1);
        step();
        check_eq("bp_c_count0", 32'(out0_count), 1);
        check_eq("bp_c_head", out0_data, 32'hC);
        in_valid = 1'b0;
        step();
        check_eq("bp_empty0", 32'(out0_count), 0);

        // Independence: port 0 full and stalled, port 1 still accepts.
        out0_ready = 1'b0;
        send(1'b0, 32'h11);
        send(1'b0, 32'h22);
        in_ctl  = 1'b1;
        in_data = 32'h5555AAAA;
        #1;
        check_eq("indep_in_ready", 32'(in_ready), 1);
        step();
        check_eq("indep_v1", 32'(out1_valid), 1);
        check_eq("indep_d1", out1_data, 32'h5555AAAA);
        check_eq("indep_count0", 32'(out0_count), 2);
        check_eq("indep_head0", out0_data, 32'h11);
        in_valid = 1'b0;
        step();
        out0_ready = 1'b1;
        step();
        step();
        check_eq("indep_drain0", 32'(out0_count), 0);

        // Simultaneous push/pop across pointer wraps on port 1.
        out1_ready = 1'b0;
        send(1'b1, 32'h10);
        out1_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send(1'b1, 32'h10 + 32'(i));
            check_eq("pp_count1", 32'(out1_count), 1);
            check_eq("pp_head1", out1_data, 32'h10 + 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("pp_drain1", 32'(out1_count), 0);

        // Reset mid-operation with both buffers full.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 32'h31);
        send(1'b0, 32'h32);
        send(1'b1, 32'h41);
        send(1'b1, 32'h42);
        check_eq("mid_full0", 32'(out0_count), 2);
        check_eq("mid_full1", 32'(out1_count), 2);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid_rst_count0", 32'(out0_count), 0);
        check_eq("mid_rst_count1", 32'(out1_count), 0);
        check_eq("mid_rst_valid0", 32'(out0_valid), 0);
        check_eq("mid_rst_valid1", 32'(out1_valid), 0);
        out0_ready = 1'b1;
        send(1'b0, 32'h77);
        check_eq("mid_first_word", out0_data, 32'h77);
        in_valid = 1'b0;
        step();
        step();

        check_eq("sb_left0", q0.size(), 0);
        check_eq("sb_left1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
